baud_div_ctrl: RTL
==================

# baud_div_ctrl

Host-side configuration controller for the UART baud-rate generator. It holds shadow copies of the 12-bit divisor (DLL/DLH) written over a simple byte register bus. On command it commits them to the generator only on a `br` rising edge, so the generator never sees a half-updated divisor mid-period. It also gates the generator's use with an enable bit and reports busy/error status back to the host.

## Interface
Parameters:
- `DEF_DLL`, 8'd27 – reset value of the applied and shadow DLL.
- `DEF_DLH`, 4'd0 – reset value of the applied and shadow DLH.
- `SETTLE_CYCLES`, 4 – clocks held in SETTLE after an apply (1..255).
- `TIMEOUT_CYCLES`, 16'd65535 – WAIT_EDGE watchdog limit. Used only when the watchdog is compiled in.

Ports:
- `clk` input 1 – system clock, all logic on rising edge.
- `rst_n` input 1 – asynchronous active-low reset.
- `addr` input 2 – register select: 0 DLL, 1 DLH, 2 CTRL, 3 STATUS.
- `wr_en` input 1 – single-cycle write strobe.
- `rd_en` input 1 – single-cycle read strobe.
- `wdata` input 8 – write data.
- `rdata` output 8 – registered read data.
- `br` input 1 – baud output fed back from the generator.
- `dll` output 8 – applied divisor low byte, to the generator.
- `dlh` output 4 – applied divisor high nibble, to the generator.
- `baud_en` output 1 – enable for downstream TX/RX use of `br`.
- `busy` output 1 – high in any state other than IDLE.

## Operation
- Registers:
  - DLL shadow: 8 bits, R/W.
  - DLH shadow: `wdata[3:0]`; reads return upper nibble 0.
  - CTRL write: bit0 = commit (self-clearing, reads 0); bit1 = `baud_en` (R/W).
  - STATUS (read-only; a read clears bits 2–4):
    - bit0 busy
    - bit1 applied (sticky until next commit)
    - bit2 overrun
    - bit3 div_err
    - bit4 timeout
- Shadow writes while `busy`=1 are dropped and set overrun. Commit while `busy`=1 is ignored and sets overrun.
- Divisor check on commit: if {DLH,DLL} shadow < 12'd2, the commit is rejected. div_err is set, the state stays IDLE, and outputs are unchanged.
- FSM states: IDLE, WAIT_EDGE, APPLY, SETTLE.
  - IDLE -> WAIT_EDGE on a valid commit with `baud_en`=1.
  - IDLE -> APPLY directly on a valid commit with `baud_en`=0.
  - WAIT_EDGE -> APPLY on a `br` rising edge, detected as `br` & ~`br_q` with `br_q` registered.
  - APPLY (one cycle): `dll`/`dlh` load from the shadows; applied is set. Next state is SETTLE.
  - SETTLE counts `SETTLE_CYCLES` clocks, then returns to IDLE.
- Clearing `baud_en` while in WAIT_EDGE forces APPLY on the next clock.
- Simultaneous read of STATUS and a set event in the same cycle: the set wins and the bit stays 1.
- Simultaneous `wr_en` and `rd_en`: both are performed. Read returns the pre-write value.

## Timing
- Reset values:
  - `dll`=`DEF_DLL`, `dlh`=`DEF_DLH`, shadows equal to the defaults.
  - `baud_en`=0, `busy`=0, `rdata`=0.
  - FSM in IDLE, all status bits 0, `br_q`=0.
- Read latency is 1 clock: `rdata` is valid the cycle after `rd_en` and holds until the next read.
- Write takes effect at the clock edge where `wr_en`=1.
- Commit to `busy`=1: 1 clock.
- Edge to applied divisor: the `br` rising edge is seen at edge N, and `dll`/`dlh` change at edge N+2 (WAIT_EDGE->APPLY at N+1, outputs registered at N+2).
- `busy` deasserts `SETTLE_CYCLES`+1 clocks after the APPLY cycle.
- `rst_n` low mid-sequence aborts immediately to reset values. No partial divisor update may ever be visible.
- The SETTLE counter width is 8 bits. The TIMEOUT counter is 16 bits and saturates; it never wraps.

## Configuration
- `BAUD_DIV_CTRL_TIMEOUT_EN` defined:
  - A 16-bit counter runs in WAIT_EDGE.
  - After `TIMEOUT_CYCLES` clocks with no `br` edge, the FSM forces APPLY and sets the timeout status bit.
- Not defined:
  - WAIT_EDGE waits indefinitely (exit only on a `br` edge or on `baud_en` clearing).
  - STATUS bit4 reads 0 and the counter logic is absent.

## Test plan
- Reset: hold `rst_n`=0 with `br` toggling -> `dll`=27, `dlh`=0, `baud_en`=0, `busy`=0. A STATUS read returns 8'h00.
- Safe apply:
  - Write DLL=8'h40, DLH=4'h1, then CTRL=8'h03.
  - Required: `busy`=1 next clock; `dll`/`dlh` unchanged until 2 clocks after a `br` rising edge, then 8'h40/4'h1.
  - `busy` clears after `SETTLE_CYCLES`+1 clocks. STATUS reads 8'h02.
- Invalid divisor: DLL=8'h01, DLH=0, commit -> no state change, `busy` stays 0. STATUS reads 8'h08, then 8'h00 on the next read.
- Overrun: during WAIT_EDGE, write DLL=8'hFF and issue a second commit -> shadow DLL still reads the old value. STATUS bit2=1 and the applied divisor is the first value.
- Disabled path: `baud_en`=0, commit DLL=8'h10 -> APPLY 1 clock after commit with no `br` edge needed, and `dll`=8'h10 two clocks after the CTRL write.
- Timeout (macro defined, `TIMEOUT_CYCLES`=100): hold `br`=0, commit -> apply after 100 WAIT_EDGE clocks. STATUS bit4=1.

Source files
------------

// File: rtl/baud_div_ctrl.sv
// Host-side divisor shadow/commit controller for the UART baud generator.
// Optional WAIT_EDGE watchdog compiled in with `define BAUD_DIV_CTRL_TIMEOUT_EN.
module baud_div_ctrl #(
   parameter logic [7:0]  DEF_DLL        = 8'd27,
   parameter logic [3:0]  DEF_DLH        = 4'd0,
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] addr,
   input  logic       wr_en,
   input  logic       rd_en,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   input  logic       br,
   output logic [7:0] dll,
   output logic [3:0] dlh,
   output logic       baud_en,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, WAIT_EDGE, APPLY, SETTLE} state_t;

   localparam logic [1:0] A_DLL    = 2'd0;
   localparam logic [1:0] A_DLH    = 2'd1;
   localparam logic [1:0] A_CTRL   = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [7:0] dll_sh;
   logic [3:0] dlh_sh;
   logic [7:0] settle_cnt;
   logic       br_q, br_rise_q;
   logic       applied_q, overrun_q, div_err_q, timeout_st;

   logic idle, wr_dll, wr_dlh, wr_ctrl, rd_status;
   logic commit_req, div_ok, commit_ok, overrun_set, div_err_set;
   logic tmo_expire, tmo_set;

   assign idle       = (state_q == IDLE);
   assign busy       = ~idle;
   assign wr_dll     = wr_en && (addr == A_DLL);
   assign wr_dlh     = wr_en && (addr == A_DLH);
   assign wr_ctrl    = wr_en && (addr == A_CTRL);
   assign rd_status  = rd_en && (addr == A_STATUS);
   assign commit_req = wr_ctrl && wdata[0];

   // A divisor of 0 or 1 would stall or alias the generator, so refuse it.
   assign div_ok      = ({dlh_sh, dll_sh} >= 12'd2);
   assign commit_ok   = commit_req && idle && div_ok;
   assign div_err_set = commit_req && idle && !div_ok;
   assign overrun_set = ((wr_dll || wr_dlh) && busy) || (commit_req && busy);
   assign tmo_set     = (state_q == WAIT_EDGE) && tmo_expire && !br_rise_q && baud_en;

`ifdef BAUD_DIV_CTRL_TIMEOUT_EN
   logic [15:0] tmo_cnt;
   logic        timeout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt   <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state_q != WAIT_EDGE)
            tmo_cnt <= '0;
         else if (tmo_cnt != 16'hFFFF)
            tmo_cnt <= tmo_cnt + 16'd1;

         if (tmo_set)
            timeout_q <= 1'b1;
         else if (rd_status)
            timeout_q <= 1'b0;
      end
   end

   assign tmo_expire = (state_q == WAIT_EDGE) &&
                       (({1'b0, tmo_cnt} + 17'd1) >= {1'b0, TIMEOUT_CYCLES});
   assign timeout_st = timeout_q;
`else
   logic tmo_unused;
   assign tmo_unused = ^{TIMEOUT_CYCLES, tmo_set};
   assign tmo_expire = 1'b0;
   assign timeout_st = 1'b0;
`endif

   // The edge pulse is registered so the FSM reacts one clock after br is sampled high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_q      <= 1'b0;
         br_rise_q <= 1'b0;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
         br_q      <= br;
         br_rise_q <= br & ~br_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      case (state_q)
         IDLE:      if (commit_ok) state_d = wdata[1] ? WAIT_EDGE : APPLY;
         WAIT_EDGE: if (br_rise_q || !baud_en || tmo_expire) state_d = APPLY;
         APPLY:     state_d = SETTLE;
         SETTLE:    if (settle_cnt == SETTLE_LAST) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) settle_cnt <= '0;
      else if (state_q != SETTLE) settle_cnt <= '0;
      else settle_cnt <= settle_cnt + 8'd1;
   end

   // Shadows, control and the applied divisor; dll/dlh only ever move together in APPLY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dll_sh  <= DEF_DLL;
         dlh_sh  <= DEF_DLH;
         dll     <= DEF_DLL;
         dlh     <= DEF_DLH;
         baud_en <= 1'b0;
      end else begin
         if (wr_dll && idle) dll_sh <= wdata;
         if (wr_dlh && idle) dlh_sh <= wdata[3:0];
         if (wr_ctrl)        baud_en <= wdata[1];
         if (state_q == APPLY) begin
            dll <= dll_sh;
            dlh <= dlh_sh;
         end
      end
   end

   // Status: set events take priority over the clear-on-read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         applied_q <= 1'b0;
         overrun_q <= 1'b0;
         div_err_q <= 1'b0;
      end else begin
         if (state_q == APPLY)        applied_q <= 1'b1;
         else if (commit_req && idle) applied_q <= 1'b0;

         if (overrun_set)    overrun_q <= 1'b1;
         else if (rd_status) overrun_q <= 1'b0;

         if (div_err_set)    div_err_q <= 1'b1;
         else if (rd_status) div_err_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (rd_en) begin
         case (addr)
            A_DLL:   rdata <= dll_sh;
            A_DLH:   rdata <= {4'h0, dlh_sh};
            A_CTRL:  rdata <= {6'b0, baud_en, 1'b0};
            default: rdata <= {3'b0, timeout_st, div_err_q, overrun_q, applied_q, busy};
         endcase
      end
   end

endmodule
